// File: rtl/fc_cu_pkg.sv
// fc_cu_pkg: FSM state type and width helper shared by the FC layer control unit
package fc_cu_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} fc_state_e;
  // Address/counter width for n distinct values, never narrower than one bit
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/fc_cu_delay_line.sv
// fc_cu_delay_line: DEPTH-stage 1-bit shift register aligning control with the MAC pipeline
module fc_cu_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] sr_q, sr_d;
  if (DEPTH == 1) begin : g_one
    // Single stage: just capture the input
    always_comb sr_d = d;
  end else begin : g_many
    // Shift towards the MSB, new sample enters at bit 0
    always_comb sr_d = {sr_q[DEPTH-2:0], d};
  end
  // Pipeline stages, cleared by the asynchronous reset
  always_ff @(posedge clk or posedge reset)
    if (reset) sr_q <= '0;
    else sr_q <= sr_d;
  assign q = sr_q[DEPTH-1];
endmodule

// File: rtl/fc_layer_cu.sv
// fc_layer_cu: FC layer sequencer; define FC_CU_BACKPRESSURE_EN to add the next_ready handshake
module fc_layer_cu
  import fc_cu_pkg::*;
#(
  parameter int IFM_DEPTH = 32,
  parameter int OFM_DEPTH = 10,
  parameter int LANES = 1,
  parameter int PIPE_LAT = 2,
  localparam int GROUPS = OFM_DEPTH / LANES,
  localparam int WM_AW = clog2_min1(IFM_DEPTH * GROUPS),
  localparam int IFM_AW = clog2_min1(IFM_DEPTH),
  localparam int GRP_AW = clog2_min1(GROUPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_from_previous,
`ifdef FC_CU_BACKPRESSURE_EN
  input  logic              next_ready,
`endif
  output logic              end_to_previous,
  output logic              wm_addr_sel,
  output logic              wm_enable_read,
  output logic [WM_AW-1:0]  wm_address_read,
  output logic [IFM_AW-1:0] sel_ifm,
  output logic              bias_sel,
  output logic              acc_enable,
  output logic              enable_write_next,
  output logic [GRP_AW-1:0] ofm_group,
  output logic              output_ready
);
  localparam int DR_W = clog2_min1(PIPE_LAT);
  fc_state_e         state_q, state_d;
  logic [IFM_AW-1:0] elem_q, elem_d;
  logic [GRP_AW-1:0] grp_q, grp_d;
  logic [DR_W-1:0]   drain_q, drain_d;
  logic              ordy_q, ordy_d;
  logic              accept, last_elem, last_drain, last_grp, in_read, first_beat;
`ifdef FC_CU_BACKPRESSURE_EN
  assign accept = next_ready;
`else
  assign accept = 1'b1;
`endif
  assign in_read    = state_q == READ;
  assign first_beat = in_read && elem_q == '0;
  assign last_elem  = elem_q == IFM_AW'(IFM_DEPTH - 1);
  assign last_drain = drain_q == DR_W'(PIPE_LAT - 1);
  assign last_grp   = grp_q == GRP_AW'(GROUPS - 1);
  // Next-state and counter logic; output_ready fires the cycle after the last group is accepted
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    grp_d   = grp_q;
    drain_d = drain_q;
    ordy_d  = 1'b0;
    case (state_q)
      IDLE: if (start_from_previous) begin
        state_d = READ;
        elem_d  = '0;
        grp_d   = '0;
      end
      READ: begin
        elem_d  = last_elem ? '0 : elem_q + 1'b1;
        drain_d = '0;
        state_d = last_elem ? DRAIN : READ;
      end
      DRAIN: begin
        drain_d = last_drain ? '0 : drain_q + 1'b1;
        state_d = last_drain ? WRITE : DRAIN;
      end
      WRITE: if (accept) begin
        grp_d   = last_grp ? '0 : grp_q + 1'b1;
        state_d = last_grp ? IDLE : READ;
        ordy_d  = last_grp;
      end
      default: state_d = IDLE;
    endcase
  end
  // Control state registers, asynchronously returned to IDLE with cleared counters
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      elem_q  <= '0;
      grp_q   <= '0;
      drain_q <= '0;
      ordy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      grp_q   <= grp_d;
      drain_q <= drain_d;
      ordy_q  <= ordy_d;
    end
  fc_cu_delay_line #(.DEPTH(PIPE_LAT)) u_bias_dl (.clk(clk), .reset(reset), .d(first_beat), .q(bias_sel));
  fc_cu_delay_line #(.DEPTH(PIPE_LAT)) u_acc_dl (.clk(clk), .reset(reset), .d(in_read), .q(acc_enable));
  assign end_to_previous   = state_q == IDLE;
  assign wm_addr_sel       = in_read;
  assign wm_enable_read    = in_read;
  assign sel_ifm           = elem_q;
  assign wm_address_read   = WM_AW'(grp_q) * WM_AW'(IFM_DEPTH) + WM_AW'(elem_q);
  assign enable_write_next = state_q == WRITE && accept;
  assign ofm_group         = state_q == WRITE ? grp_q : '0;
  assign output_ready      = ordy_q;
endmodule

// File: tb/tb_fc_layer_cu.sv
// tb_fc_layer_cu: directed checks of fc_layer_cu with IFM_DEPTH=4, PIPE_LAT=2, two groups
module tb_fc_layer_cu;
  logic clk = 1'b0;
  logic reset, start_from_previous, next_ready;
  logic etp, asel, rd, bias, acc, wr, ordy;
  logic [2:0] addr;
  logic [1:0] sel;
  logic [0:0] og;
  logic etp2, asel2, rd2, bias2, acc2, wr2, ordy2;
  logic [2:0] addr2;
  logic [1:0] sel2;
  logic [0:0] og2;
  int pass_n = 0, total_n = 0;

  always #5 clk = ~clk;

  fc_layer_cu #(.IFM_DEPTH(4), .OFM_DEPTH(2), .LANES(1), .PIPE_LAT(2)) dut (
    .clk(clk), .reset(reset), .start_from_previous(start_from_previous),
`ifdef FC_CU_BACKPRESSURE_EN
    .next_ready(next_ready),
`endif
    .end_to_previous(etp), .wm_addr_sel(asel), .wm_enable_read(rd),
    .wm_address_read(addr), .sel_ifm(sel), .bias_sel(bias), .acc_enable(acc),
    .enable_write_next(wr), .ofm_group(og), .output_ready(ordy));

  fc_layer_cu #(.IFM_DEPTH(4), .OFM_DEPTH(4), .LANES(2), .PIPE_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .start_from_previous(start_from_previous),
`ifdef FC_CU_BACKPRESSURE_EN
    .next_ready(next_ready),
`endif
    .end_to_previous(etp2), .wm_addr_sel(asel2), .wm_enable_read(rd2),
    .wm_address_read(addr2), .sel_ifm(sel2), .bias_sel(bias2), .acc_enable(acc2),
    .enable_write_next(wr2), .ofm_group(og2), .output_ready(ordy2));

  typedef struct {
    logic st, etp, rd;
    int addr, sel;
    logic bias, acc, wr;
    int og;
    logic ordy;
  } vec_t;
  vec_t tbl[17];

  function automatic vec_t v(input logic st, etp, rd, input int addr, sel,
                             input logic bias, acc, wr, input int og, input logic ordy);
    vec_t r;
    r.st = st; r.etp = etp; r.rd = rd; r.addr = addr; r.sel = sel;
    r.bias = bias; r.acc = acc; r.wr = wr; r.og = og; r.ordy = ordy;
    return r;
  endfunction

  task automatic chk(input string nm, input int k, input int act, input int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", nm, k, act, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_etp"}, -1, int'(etp), 1);
    chk({tag, "_rd"}, -1, int'(rd), 0);
    chk({tag, "_asel"}, -1, int'(asel), 0);
    chk({tag, "_addr"}, -1, int'(addr), 0);
    chk({tag, "_sel"}, -1, int'(sel), 0);
    chk({tag, "_bias"}, -1, int'(bias), 0);
    chk({tag, "_acc"}, -1, int'(acc), 0);
    chk({tag, "_wr"}, -1, int'(wr), 0);
    chk({tag, "_og"}, -1, int'(og), 0);
    chk({tag, "_ordy"}, -1, int'(ordy), 0);
  endtask

  initial begin
    reset = 1'b1;
    start_from_previous = 1'b0;
    next_ready = 1'b1;
    //            st etp rd addr sel bias acc wr og ordy
    tbl[0]  = v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = v(0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    tbl[3]  = v(0, 0, 1, 2, 2, 1, 1, 0, 0, 0);
    tbl[4]  = v(0, 0, 1, 3, 3, 0, 1, 0, 0, 0);
    tbl[5]  = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[6]  = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[7]  = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[8]  = v(0, 0, 1, 4, 0, 0, 0, 0, 0, 0);
    tbl[9]  = v(0, 0, 1, 5, 1, 0, 0, 0, 0, 0);
    tbl[10] = v(0, 0, 1, 6, 2, 1, 1, 0, 0, 0);
    tbl[11] = v(0, 0, 1, 7, 3, 0, 1, 0, 0, 0);
    tbl[12] = v(0, 0, 0, 4, 0, 0, 1, 0, 0, 0);
    tbl[13] = v(0, 0, 0, 4, 0, 0, 1, 0, 0, 0);
    tbl[14] = v(0, 0, 0, 4, 0, 0, 0, 1, 1, 0);
    tbl[15] = v(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[16] = v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 17; k++) begin
      start_from_previous = tbl[k].st;
      chk("etp", k, int'(etp), int'(tbl[k].etp));
      chk("rd", k, int'(rd), int'(tbl[k].rd));
      chk("asel", k, int'(asel), int'(tbl[k].rd));
      chk("addr", k, int'(addr), tbl[k].addr);
      chk("sel", k, int'(sel), tbl[k].sel);
      chk("bias", k, int'(bias), int'(tbl[k].bias));
      chk("acc", k, int'(acc), int'(tbl[k].acc));
      chk("wr", k, int'(wr), int'(tbl[k].wr));
      if (tbl[k].wr) chk("og", k, int'(og), tbl[k].og);
      chk("ordy", k, int'(ordy), int'(tbl[k].ordy));
      chk("lanes2_addr", k, int'(addr2), tbl[k].addr);
      chk("lanes2_wr", k, int'(wr2), int'(tbl[k].wr));
      if (tbl[k].wr) chk("lanes2_og", k, int'(og2), tbl[k].og);
      chk("lanes2_ordy", k, int'(ordy2), int'(tbl[k].ordy));
      @(negedge clk);
    end

    // Reset in the middle of group 1's READ, then restart from address 0
    start_from_previous = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start_from_previous = 1'b0;
    end
    chk("rst_pre_addr", 10, int'(addr), 6);
    chk("rst_pre_bias", 10, int'(bias), 1);
    chk("rst_pre_acc", 10, int'(acc), 1);
    #1 reset = 1'b1;
    #1;
    chk_idle_outputs("rst_async");
    @(negedge clk);
    chk_idle_outputs("rst_held");
    #2 reset = 1'b0;
    @(negedge clk);
    start_from_previous = 1'b1;
    @(negedge clk);
    start_from_previous = 1'b0;
    chk("rst_restart_rd", 1, int'(rd), 1);
    chk("rst_restart_addr", 1, int'(addr), 0);
    @(negedge clk);
    chk("rst_restart_addr", 2, int'(addr), 1);
    @(negedge clk);
    chk("rst_restart_bias", 3, int'(bias), 1);
    repeat (14) @(negedge clk);
    chk("rst_restart_done_etp", 17, int'(etp), 1);

    // Start held high: back-to-back layers, start ignored while busy
    start_from_previous = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (k == 8)  chk("b2b_addr", k, int'(addr), 4);
      if (k == 10) chk("b2b_addr", k, int'(addr), 6);
      if (k == 7)  chk("b2b_wr", k, int'(wr), 1);
      if (k == 14) chk("b2b_wr", k, int'(wr), 1);
      if (k == 14) chk("b2b_og", k, int'(og), 1);
      if (k == 15) chk("b2b_ordy", k, int'(ordy), 1);
      if (k == 15) chk("b2b_etp", k, int'(etp), 1);
      if (k == 16) chk("b2b_rd", k, int'(rd), 1);
      if (k == 16) chk("b2b_addr", k, int'(addr), 0);
      if (k == 22) chk("b2b_wr", k, int'(wr), 1);
      if (k == 22) chk("b2b_og", k, int'(og), 0);
      if (k == 29) chk("b2b_wr", k, int'(wr), 1);
      if (k == 29) chk("b2b_og", k, int'(og), 1);
      if (k == 30) chk("b2b_ordy", k, int'(ordy), 1);
      if (k == 31) chk("b2b_etp", k, int'(etp), 1);
      if (k == 31) chk("b2b_rd", k, int'(rd), 0);
      if (k == 16) start_from_previous = 1'b0;
      @(negedge clk);
    end

`ifdef FC_CU_BACKPRESSURE_EN
    // next_ready low for five cycles at the first WRITE
    start_from_previous = 1'b1;
    for (int k = 0; k < 22; k++) begin
      next_ready = !(k >= 7 && k <= 11);
      if (k == 7)  chk("bp_wr", k, int'(wr), 0);
      if (k == 11) chk("bp_wr", k, int'(wr), 0);
      if (k == 11) chk("bp_rd", k, int'(rd), 0);
      if (k == 12) chk("bp_wr", k, int'(wr), 1);
      if (k == 12) chk("bp_og", k, int'(og), 0);
      if (k == 13) chk("bp_rd", k, int'(rd), 1);
      if (k == 13) chk("bp_addr", k, int'(addr), 4);
      if (k == 19) chk("bp_wr", k, int'(wr), 1);
      if (k == 19) chk("bp_og", k, int'(og), 1);
      if (k == 15) chk("bp_ordy", k, int'(ordy), 0);
      if (k == 20) chk("bp_ordy", k, int'(ordy), 1);
      if (k == 0) start_from_previous = 1'b0;
      @(negedge clk);
    end
    next_ready = 1'b1;
`endif

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
